// File: rtl/aes_job_scheduler_pkg.sv
// aes_sched_pkg: shared state encoding, block width and operand slicing helper for the AES job scheduler.
package aes_sched_pkg;
   localparam int AES_BLK_W = 128;
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_t;
   function automatic int blk_lo(input int i);
      return i * AES_BLK_W;
   endfunction
endpackage

// File: rtl/aes_job_scheduler_if.sv
// aes_job_scheduler_if: requester-side job and response bundle; master = requester fabric, slave = scheduler.
interface aes_job_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) ();
   logic [N_REQ-1:0]                          req_valid;
   logic [N_REQ-1:0]                          req_ready;
   logic [N_REQ*aes_sched_pkg::AES_BLK_W-1:0] req_plaintext;
   logic [N_REQ*aes_sched_pkg::AES_BLK_W-1:0] req_key;
   logic                                      rsp_valid;
   logic                                      rsp_ready;
   logic [ID_W-1:0]                           rsp_id;
   logic [aes_sched_pkg::AES_BLK_W-1:0]       rsp_data;
   logic                                      rsp_err;
   modport master (
      output req_valid, req_plaintext, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
   modport slave (
      input  req_valid, req_plaintext, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping N_REQ-1 -> 0; one-hot grant plus index.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             vld
);
   logic [ID_W-1:0] j;
   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      j   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = ID_W'((int'(ptr) + k) % N_REQ);
         if (!vld && req[j]) begin
            vld    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin sharing of one iterative AES-128 core among N_REQ requesters.
// Optional run timeout (abort with rsp_err, then re-enter INIT) is enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler
   import aes_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int INIT_WAIT   = 12,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   aes_job_scheduler_if.slave   bus,
   output logic                 core_start,
   output logic [AES_BLK_W-1:0] core_plaintext,
   output logic [AES_BLK_W-1:0] core_key,
   input  logic                 core_ready,
   input  logic [AES_BLK_W-1:0] core_cipher_text,
   output logic                 busy
);
   localparam int IW = $clog2(INIT_WAIT + 1);

   if (N_REQ < 2 || N_REQ > 8 || ID_W < $clog2(N_REQ) || INIT_WAIT < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("aes_job_scheduler: unsupported parameter combination");
   end

   state_t           state, state_nx;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx, ptr;
   logic             gnt_vld, timeout;
   logic [IW-1:0]    init_cnt;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .vld (gnt_vld)
   );

   always_ff @(posedge clk) state <= reset ? S_INIT : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_INIT:   state_nx = (init_cnt == IW'(INIT_WAIT - 1)) ? S_IDLE : S_INIT;
         S_IDLE:   state_nx = gnt_vld ? S_LAUNCH : S_IDLE;
         S_LAUNCH: state_nx = S_RUN;
         S_RUN:    state_nx = (core_ready || timeout) ? S_RESP : S_RUN;
         S_RESP:   state_nx = !bus.rsp_ready ? S_RESP : bus.rsp_err ? S_INIT : S_IDLE;
         default:  state_nx = S_INIT;
      endcase
   end

   always_comb begin
      core_start    = state == S_LAUNCH;
      busy          = state != S_IDLE;
      bus.rsp_valid = state == S_RESP;
      bus.req_ready = (state == S_IDLE) ? gnt : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_cnt       <= '0;
         ptr            <= '0;
         core_plaintext <= '0;
         core_key       <= '0;
         bus.rsp_id     <= '0;
         bus.rsp_data   <= '0;
      end else begin
         init_cnt <= (state == S_INIT) ? init_cnt + 1'b1 : '0;
         if (state == S_IDLE && gnt_vld) begin
            core_plaintext <= bus.req_plaintext[blk_lo(int'(gnt_idx)) +: AES_BLK_W];
            core_key       <= bus.req_key[blk_lo(int'(gnt_idx)) +: AES_BLK_W];
            bus.rsp_id     <= gnt_idx;
            ptr            <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
         // core_ready is only meaningful in RUN; late pulses from an abandoned run fall here
         if (state == S_RUN && core_ready) bus.rsp_data <= core_cipher_text;
         else if (timeout) bus.rsp_data <= '0;
      end
   end

`ifdef AES_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] run_cnt;
   logic          err_q;
   always_ff @(posedge clk) begin
      run_cnt <= (reset || state != S_RUN) ? '0 : run_cnt + 1'b1;
      if (reset) err_q <= 1'b0;
      else if (state == S_RUN && (core_ready || timeout)) err_q <= timeout;
   end
   assign timeout     = state == S_RUN && !core_ready && run_cnt == TW'(TIMEOUT_CYC - 1);
   assign bus.rsp_err = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif
endmodule
